// File: rtl/ixc_change_fifo_12_pkg.sv
// Purpose: shared types and constants for the 12-bit change-capture probe.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, FIFO entry struct (default timestamp width), drop counter limits.
package ixc_probe_pkg;

    localparam int DATA_W   = 12;
    localparam int TS_W_DEF = 16;
    localparam int DROP_W   = 8;

    // drop_cnt parks here instead of wrapping back to zero
    localparam logic [DROP_W-1:0] DROP_SAT = 8'hFF;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // One captured change, at the default timestamp width
    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [TS_W_DEF-1:0] ts;
    } entry_t;

endpackage

// File: rtl/ixc_change_fifo_12_if.sv
// Purpose: probe-side bundle: capture controls in, change stream and overflow status out.
// Latency: n/a (wiring only).
// Backpressure: out_valid/out_ready handshake on the change stream.
// Modports: master = probe block (drives out_*, ovf, drop_cnt); slave = producer/consumer side.
interface ixc_change_fifo_12_if #(
    parameter int TSW = 16
);
    logic           en;
    logic [11:0]    din;
    logic           clr;
    logic           out_ready;
    logic           out_valid;
    logic [11:0]    out_data;
    logic [TSW-1:0] out_ts;
    logic           ovf;
    logic [7:0]     drop_cnt;

    modport master (
        input  en, din, clr, out_ready,
        output out_valid, out_data, out_ts, ovf, drop_cnt
    );

    modport slave (
        output en, din, clr, out_ready,
        input  out_valid, out_data, out_ts, ovf, drop_cnt
    );
endinterface

// File: rtl/ixc_change_fifo_12_fifo.sv
// Purpose: synchronous FIFO, storage plus wrap-bit pointers, head shown combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
// Ports: clk, rst_n (sync, active-low), push/push_dat, pop/pop_dat, full, empty.
module ixc_sync_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra MSB on each pointer tells full apart from empty
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is never reset; the pointers alone decide what is valid.
    // On full+pop the write slot equals the read slot, and the read below
    // still returns the old entry for the rest of this cycle.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    // Forced to zero when empty so uninitialised storage never reaches the outputs
    assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ixc_change_fifo_12.sv
// Purpose: timestamps changes of a 12-bit probed value and queues them; counts drops on overflow.
// Latency: a change in cycle N appears on out_* in cycle N+1 when the queue was empty.
// Backpressure: out_ready low holds the head; a change meeting a full queue is dropped (ovf, drop_cnt).
// Ports: clk, rst_n (sync, active-low), bus (master modport of ixc_change_fifo_12_if).
module ixc_change_fifo_12
    import ixc_probe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TSW   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ixc_change_fifo_12_if.master  bus
);
    localparam int EW = DATA_W + TSW;

    state_t              state;
    logic [TSW-1:0]      ts;
    logic [DATA_W-1:0]   prev;
    logic                ovf_q;
    logic [DROP_W-1:0]   drop_q;

    logic                change;
    logic                pop;
    logic                push;
    logic                drop;
    logic                full;
    logic                empty;
    logic [EW-1:0]       head;

    // PRIME always records the current value so a new capture window starts with a reference entry
    assign change = (state == ST_PRIME) || ((state == ST_RUN) && (bus.din != prev));
    assign pop    = !empty && bus.out_ready;
    assign push   = change && (!full || pop);
    assign drop   = change && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_OFF;
            prev  <= '0;
        end else begin
            if (state != ST_OFF) prev <= bus.din;
            case (state)
                ST_OFF:   if (bus.en) state <= ST_PRIME;
                ST_PRIME: state <= bus.en ? ST_RUN : ST_OFF;
                ST_RUN:   if (!bus.en) state <= ST_OFF;
                default:  state <= ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts     <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            ts <= ts + 1'b1;
            // A drop in the clearing cycle survives the clear as the first new drop
            if (bus.clr) begin
                ovf_q  <= drop;
                drop_q <= drop ? DROP_W'(1) : '0;
            end else if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != DROP_SAT) drop_q <= drop_q + 1'b1;
            end
        end
    end

    ixc_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({bus.din, ts}),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty)
    );

    assign bus.out_valid = !empty;
    assign bus.out_data  = head[EW-1:TSW];
    assign bus.out_ts    = head[TSW-1:0];
    assign bus.ovf       = ovf_q;
    assign bus.drop_cnt  = drop_q;

endmodule

// File: doc/ixc_change_fifo_12.md
IXC_CHANGE_FIFO_12 -- requirements
Module: ixc_change_fifo_12

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries, power of two, 2..16.
REQ-002 Parameter TSW, default 16: timestamp width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 en  input  1  capture enable.
REQ-006 din  input  12  probed value, driven by the L output of the 12-bit assign stage.
REQ-007 clr  input  1  clears ovf and drop_cnt.
REQ-008 out_ready  input  1  consumer accepts the head entry.
REQ-009 out_valid  output  1  head entry present.
REQ-010 out_data  output  12  din value of head entry.
REQ-011 out_ts  output  TSW  timestamp of head entry.
REQ-012 ovf  output  1  sticky: at least one change dropped.
REQ-013 drop_cnt  output  8  saturating count of dropped changes.

Function
REQ-014 ts counter shall increment by 1 every cycle and wrap from 2^TSW-1 to 0.
REQ-015 Control FSM shall have states OFF, PRIME and RUN.
- OFF: entered from reset; en=1 -> PRIME.
- PRIME: captures din unconditionally, then -> RUN; en=0 -> OFF.
- RUN: en=0 -> OFF.
REQ-016 prev register shall load din every cycle in PRIME or RUN.
REQ-017 A change event shall fire in PRIME always, and in RUN when din != prev.
REQ-018 A change event shall push {din, ts} when FIFO is not full, or when full with a pop in the same cycle.
REQ-019 A change event with FIFO full and no same-cycle pop shall be dropped.
- Dropped event sets ovf.
- drop_cnt increments, saturating at 255.
REQ-020 Pop shall occur when out_valid && out_ready.
REQ-021 Event at cycle N shall be visible on out_valid/out_data/out_ts at cycle N+1 when FIFO was empty.
REQ-022 out_data and out_ts shall hold stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous push and pop on an empty FIFO shall not bypass: pop is impossible when empty; push is accepted.
REQ-024 clr shall zero ovf and drop_cnt next cycle; clr with a same-cycle drop shall yield ovf=1, drop_cnt=1.
REQ-025 Transition to OFF shall not flush the FIFO; stored entries remain poppable.
REQ-026 Read/write pointers shall be log2(DEPTH)+1 bits.
- Full: MSBs differ, rest equal.
- Empty: pointers equal.

Reset
REQ-027 On rst_n=0 at a clock edge, the block shall reset as follows:
- FSM=OFF, pointers=0, ts=0, prev=0.
- out_valid=0, out_data=0, out_ts=0.
- ovf=0, drop_cnt=0.
REQ-028 Reset mid-operation shall discard all FIFO contents; out_valid shall be 0 the cycle after.
REQ-029 Storage array contents shall not require reset.

Structure
REQ-030 Shared package ixc_probe_pkg shall hold the FSM state enum, the entry struct {data[11:0], ts[TSW-1:0]} and the drop_cnt saturation constant.
REQ-031 Storage plus pointers shall be one sub-module, ixc_sync_fifo.
- Parameters: width and depth.
- Outputs: full and empty.
REQ-032 FSM, change detect, ts counter and overflow logic shall live in the top.

Verification
REQ-033 Reset, en=1 at cycle 2, din=0x0A5 held: exactly one entry {0x0A5, ts=2}, out_valid at cycle 3.
REQ-034 RUN, din steps 0x001, 0x002, 0x003 on consecutive cycles, out_ready=1: three entries, ts values consecutive, order preserved.
REQ-035 DEPTH=4, out_ready=0, six distinct changes:
- Four entries stored.
- ovf=1, drop_cnt=2.
- clr -> ovf=0, drop_cnt=0, FIFO still full.
REQ-036 FIFO full, change plus out_ready=1 in the same cycle: push accepted, no drop, count stays 4.
REQ-037 Three entries queued, rst_n=0 for one cycle: out_valid=0 next cycle, FSM=OFF, ts=0.
REQ-038 ts preset near wrap (0xFFFF) and change at wrap: entries carry 0xFFFF then 0x0000; en toggled 1->0->1 with din unchanged yields a fresh PRIME entry.
